multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing a shared-memory multi-cycle MIPS-subset datapath: fetch, decode, execute, memory, writeback.
//  Drives PC/IR/register-file/ALU-mux controls and a req/ready handshake to the single instruction+data memory.
//  Sits beside the datapath; takes opcode from IR. Supports R-type, lw, sw, beq, j.
//  Adds memory-wait timeout, fault states and a retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive cycles with mem_req=1 & mem_ready=0 before bus fault (>=1)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous reset, active-low
//  opcode       in   6      IR[31:26]
//  mem_ready    in   1      memory completes current request this cycle
//  mem_req      out  1      memory request, held until mem_ready
//  mem_we       out  1      write (valid with mem_req)
//  i_or_d       out  1      0=PC address, 1=ALUOut address
//  ir_write     out  1      load IR (and MDR) this cycle
//  pc_write     out  1      unconditional PC load
//  pc_write_cond out 1      PC load if ALU zero
//  pc_source    out  2      00=ALU, 01=ALUOut, 10=jump target
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op       out  2      00=add, 01=sub, 10=funct
//  reg_dst      out  1      1=rd, 0=rt
//  reg_write    out  1      register-file write
//  mem_to_reg   out  1      writeback source MDR
//  bus_error    out  1      sticky: memory timeout
//  illegal_op   out  1      sticky: unsupported opcode
//  state_o      out  4      current state, debug
//  instr_count  out  CNT_W  retired instructions, wraps
// BEHAVIOUR
//  Reset: rst_n=0 at edge -> state FETCH, wait counter 0, instr_count 0, sticky flags 0.
//   While rst_n=0, all control outputs forced 0 combinationally, including mid-transaction (mem_req drops immediately).
//  Opcodes: R=6'h00, lw=6'h23, sw=6'h2B, beq=6'h04, j=6'h02. Others -> FAULT with illegal_op=1.
//  States, all unlisted outputs 0:
//   FETCH: mem_req, i_or_d=0, src_a=0, src_b=01, alu_op=00.
//     On mem_ready: ir_write=1, pc_write=1, pc_source=00, next DECODE. Otherwise stay.
//   DECODE: src_a=0, src_b=11, alu_op=00. Branch target goes to ALUOut. Next state by opcode:
//     R->EXEC, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP.
//   MEM_ADDR: src_a=1, src_b=10, alu_op=00. lw->MEM_RD, sw->MEM_WR.
//   MEM_RD: mem_req, i_or_d=1. On mem_ready: ir_write=0, MDR loads externally, next MEM_WB.
//   MEM_WB: reg_write, mem_to_reg=1, reg_dst=0. Retire; next FETCH.
//   MEM_WR: mem_req, mem_we, i_or_d=1. On mem_ready: retire, next FETCH.
//   EXEC: src_a=1, src_b=00, alu_op=10. Next ALU_WB.
//   ALU_WB: reg_write, reg_dst=1, mem_to_reg=0. Retire; next FETCH.
//   BRANCH: src_a=1, src_b=00, alu_op=01, pc_write_cond, pc_source=01. Retire; next FETCH.
//   JUMP: pc_write, pc_source=10. Retire; next FETCH.
//   FAULT: all controls 0. Held until reset.
//  Latency (zero-wait memory): R 4 cycles, lw 5, sw 4, beq 3, j 3.
//  Retire: instr_count+1 on the cycle leaving a retiring state. Wraps 2^CNT_W-1 -> 0 silently.
//  Wait counter:
//   Increments each cycle mem_req=1 & mem_ready=0; clears on mem_ready or state change.
//   When it reaches MEM_TIMEOUT (while still waiting) -> FAULT, bus_error=1.
//   mem_ready in that same cycle wins: normal transition, no fault.
//  Sticky flags change only in reset. In FAULT, mem_ready is ignored.
// STRUCTURE
//  ctrl_pkg: opcode localparams, 4-bit state encoding, alu_op/pc_source/alu_src_b codes.
//  Sub-module mem_wait_timer (count, clear, timeout compare). FSM, output decode and counter stay in top.
// TESTING
//  1. rst_n=0 mid MEM_RD (mem_req=1) -> mem_req=0 same cycle; after release FETCH with mem_req=1, instr_count=0.
//  2. R-type, mem_ready=1 always -> FETCH,DECODE,EXEC,ALU_WB; reg_write=1, reg_dst=1 in cycle 4; instr_count=1.
//  3. lw, FETCH ready after 3 waits -> ir_write only on ready cycle; MEM_WB has mem_to_reg=1, reg_dst=0.
//  4. sw then beq then j -> mem_we only in MEM_WR; pc_write_cond+pc_source=01 in BRANCH; pc_write+pc_source=10 in JUMP; count=3.
//  5. MEM_TIMEOUT=4, mem_ready held 0 -> FAULT on 5th cycle, bus_error=1; ready at timeout cycle -> no fault.
//  6. opcode 6'h3F -> FAULT after DECODE, illegal_op=1; counter preset 2^CNT_W-1 + retire -> 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, FSM states,
// datapath mux codes and the packed control word driven toward the datapath.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_ALU_WB   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_FAULT    = 4'd10
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // True for the states that hold mem_req and can stall on mem_ready.
  function automatic logic is_mem_state(input state_e st);
    return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in, control word out.
interface multicycle_ctrl_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive stalled memory cycles; timeout_o fires on the cycle the count
// would reach MEM_TIMEOUT while still stalled, so the FSM can divert to FAULT that edge.
module multicycle_ctrl_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = wait_i && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || timeout_o) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a shared-memory multi-cycle MIPS-subset datapath, with memory
// wait timeout, sticky fault flags and a wrapping retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus,
  output logic               bus_error,
  output logic               illegal_op,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             bus_err_q, ill_op_q;
  ctrl_t            ctl;
  logic             retire, set_bus_err, set_ill_op;
  logic             mem_wait, wait_clear, timeout;

  assign mem_wait   = rst_n && is_mem_state(state_q) && !bus.mem_ready;
  assign wait_clear = !rst_n || !is_mem_state(state_q) || bus.mem_ready;

  multicycle_ctrl_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wait_i    (mem_wait),
    .clear_i   (wait_clear),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    ctl         = '0;
    retire      = 1'b0;
    set_bus_err = 1'b0;
    set_ill_op  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        if (bus.mem_ready) begin
          ctl.ir_write  = 1'b1;
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_ALU;
          state_d       = ST_DECODE;
        end else if (timeout) begin
          state_d     = ST_FAULT;
          set_bus_err = 1'b1;
        end
      end
      ST_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ctl.alu_src_b = SRCB_IMM_SH2;
        ctl.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default: begin
            state_d    = ST_FAULT;
            set_ill_op = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        if (bus.opcode == OP_LW) begin
          state_d = ST_MEM_RD;
        end else if (bus.opcode == OP_SW) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d    = ST_FAULT;
          set_ill_op = 1'b1;
        end
      end
      ST_MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout) begin
          state_d     = ST_FAULT;
          set_bus_err = 1'b1;
        end
      end
      ST_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (timeout) begin
          state_d     = ST_FAULT;
          set_bus_err = 1'b1;
        end
      end
      ST_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALU_FUNCT;
        state_d       = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_RT;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
        retire            = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
    // Reset must silence the datapath immediately, even mid-transaction.
    if (!rst_n) begin
      ctl = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      count_q   <= '0;
      bus_err_q <= 1'b0;
      ill_op_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      count_q   <= count_q + CNT_W'(1);
      if (set_bus_err) bus_err_q <= 1'b1;
      if (set_ill_op)  ill_op_q  <= 1'b1;
    end
  end

  assign bus.mem_req       = ctl.mem_req;
  assign bus.mem_we        = ctl.mem_we;
  assign bus.i_or_d        = ctl.i_or_d;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;

  assign bus_error   = bus_err_q;
  assign illegal_op  = ill_op_q;
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each driven cycle pushes the expected state/control/count/flags,
// popped and compared on the following falling edge.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bus_error, illegal_op;
  logic [3:0]    state_o;
  logic [CW-1:0] instr_count;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .bus_error   (bus_error),
    .illegal_op  (illegal_op),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  logic [15:0] act_ctl;
  assign act_ctl = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                    bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_op, bus.reg_dst, bus.reg_write, bus.mem_to_reg};

  typedef struct {
    logic [3:0]    st;
    logic [5:0]    op;
    logic          rdy;
    logic [15:0]   ctl;
    logic [CW-1:0] cnt;
    logic          be;
    logic          io;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] cnt_m;
  logic          be_m, io_m;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ctl_of(input logic [3:0] st, input logic rdy);
    logic req, we, iod, irw, pcw, pcwc, sa, rd, rw, m2r;
    logic [1:0] ps, sb, aop;
    {req, we, iod, irw, pcw, pcwc, sa, rd, rw, m2r} = '0;
    {ps, sb, aop} = '0;
    case (st)
      ST_FETCH:    begin req = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:   sb = 2'b11;
      ST_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      ST_MEM_RD:   begin req = 1; iod = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin req = 1; we = 1; iod = 1; end
      ST_EXEC:     begin sa = 1; aop = 2'b10; end
      ST_ALU_WB:   begin rw = 1; rd = 1; end
      ST_BRANCH:   begin sa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
      ST_JUMP:     begin pcw = 1; ps = 2'b10; end
      default:     ;
    endcase
    return {req, we, iod, irw, pcw, pcwc, ps, sa, sb, aop, rd, rw, m2r};
  endfunction

  task automatic push(input logic [3:0] st, input logic [5:0] op, input logic rdy,
                      input logic ret);
    exp_t e;
    e.st = st; e.op = op; e.rdy = rdy; e.ctl = ctl_of(st, rdy);
    e.cnt = cnt_m; e.be = be_m; e.io = io_m;
    sb_q.push_back(e);
    if (ret) cnt_m = cnt_m + 1'b1;
  endtask

  task automatic push_instr(input logic [5:0] op, input int fw, input int mw);
    repeat (fw) push(ST_FETCH, op, 1'b0, 1'b0);
    push(ST_FETCH, op, 1'b1, 1'b0);
    push(ST_DECODE, op, 1'b1, 1'b0);
    case (op)
      OP_RTYPE: begin push(ST_EXEC, op, 1'b1, 1'b0); push(ST_ALU_WB, op, 1'b1, 1'b1); end
      OP_LW: begin
        push(ST_MEM_ADDR, op, 1'b1, 1'b0);
        repeat (mw) push(ST_MEM_RD, op, 1'b0, 1'b0);
        push(ST_MEM_RD, op, 1'b1, 1'b0);
        push(ST_MEM_WB, op, 1'b1, 1'b1);
      end
      OP_SW: begin
        push(ST_MEM_ADDR, op, 1'b1, 1'b0);
        repeat (mw) push(ST_MEM_WR, op, 1'b0, 1'b0);
        push(ST_MEM_WR, op, 1'b1, 1'b1);
      end
      OP_BEQ: push(ST_BRANCH, op, 1'b1, 1'b1);
      OP_J:   push(ST_JUMP, op, 1'b1, 1'b1);
      default: begin io_m = 1'b1; push(ST_FAULT, op, 1'b1, 1'b0); end
    endcase
  endtask

  task automatic run();
    exp_t e;
    while (sb_q.size() > 0) begin
      bus.opcode    = sb_q[0].op;
      bus.mem_ready = sb_q[0].rdy;
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("state(exp %0d)", e.st), 32'(state_o), 32'(e.st));
      chk($sformatf("ctl(st %0d)", e.st), 32'(act_ctl), 32'(e.ctl));
      chk($sformatf("count(st %0d)", e.st), 32'(instr_count), 32'(e.cnt));
      chk($sformatf("flags(st %0d)", e.st), {30'd0, bus_error, illegal_op}, {30'd0, e.be, e.io});
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_m = '0; be_m = 1'b0; io_m = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus.opcode = OP_RTYPE; bus.mem_ready = 1'b0;
    cnt_m = '0; be_m = 1'b0; io_m = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'(ST_FETCH));
    chk("rst_ctl", 32'(act_ctl), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_flags", {30'd0, bus_error, illegal_op}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R-type, lw with stalls just under the timeout, then sw/beq/j.
    push_instr(OP_RTYPE, 0, 0);
    push_instr(OP_LW, 3, 0);
    push_instr(OP_LW, 0, 3);
    push_instr(OP_SW, 0, 2);
    push_instr(OP_BEQ, 0, 0);
    push_instr(OP_J, 0, 0);
    run();

    // Reset asserted while MEM_RD is requesting.
    bus.opcode = OP_LW; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("midrd_state", 32'(state_o), 32'(ST_MEM_RD));
    chk("midrd_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rst_ctl_drop", 32'(act_ctl), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", 32'(state_o), 32'(ST_FETCH));
    chk("post_rst_req", 32'(bus.mem_req), 32'd1);
    chk("post_rst_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;

    // Counter wrap: 2^CW jumps bring it back to zero, seen during the next R-type.
    do_reset();
    repeat (1 << CW) push_instr(OP_J, 0, 0);
    push_instr(OP_RTYPE, 0, 0);
    run();

    // Fetch timeout: TO stalled cycles, then FAULT ignores mem_ready.
    do_reset();
    repeat (TO) push(ST_FETCH, OP_RTYPE, 1'b0, 1'b0);
    be_m = 1'b1;
    repeat (3) push(ST_FAULT, OP_RTYPE, 1'b1, 1'b0);
    run();

    // Store timeout.
    do_reset();
    push(ST_FETCH, OP_SW, 1'b1, 1'b0);
    push(ST_DECODE, OP_SW, 1'b1, 1'b0);
    push(ST_MEM_ADDR, OP_SW, 1'b1, 1'b0);
    repeat (TO) push(ST_MEM_WR, OP_SW, 1'b0, 1'b0);
    be_m = 1'b1;
    repeat (2) push(ST_FAULT, OP_SW, 1'b1, 1'b0);
    run();

    // Illegal opcode.
    do_reset();
    push_instr(6'h3F, 0, 0);
    repeat (2) push(ST_FAULT, 6'h3F, 1'b1, 1'b0);
    run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
